// File: rtl/gp_reg_arbiter.sv
// rtl/gp_reg_arbiter.sv - two-master round-robin arbiter in front of one register slave
module gp_reg_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [DATA_W-1:0] m0_write_data,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_read_data,
  output logic              m0_readdatavalid,

  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [DATA_W-1:0] m1_write_data,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_read_data,
  output logic              m1_readdatavalid,

  output logic              s_read,
  output logic              s_write,
  output logic [ADDR_W-1:0] s_address,
  output logic [DATA_W-1:0] s_write_data,
  input  logic [DATA_W-1:0] s_read_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RWAIT = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   grant, grant_nxt;
  logic   last, last_nxt;

  logic              req0, req1;
  logic              g_read, g_write, g_eff_read;
  logic [ADDR_W-1:0] g_address;
  logic [DATA_W-1:0] g_write_data;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  assign g_read       = grant ? m1_read       : m0_read;
  assign g_write      = grant ? m1_write      : m0_write;
  assign g_address    = grant ? m1_address    : m0_address;
  assign g_write_data = grant ? m1_write_data : m0_write_data;
  // A simultaneous read+write is treated as a write; the read half is dropped.
  assign g_eff_read   = g_read & ~g_write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= 1'b0;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      last  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    last_nxt     = last;
    s_read       = 1'b0;
    s_write      = 1'b0;
    s_address    = '0;
    s_write_data = '0;
    case (state)
      IDLE: begin
        if (req0 && req1) begin
          grant_nxt = ~last;
          state_nxt = ISSUE;
        end else if (req0) begin
          grant_nxt = 1'b0;
          state_nxt = ISSUE;
        end else if (req1) begin
          grant_nxt = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        s_write      = g_write;
        s_read       = g_eff_read;
        s_address    = g_address;
        s_write_data = g_write_data;
        last_nxt     = grant;
        // A master that withdrew its request simply falls back to IDLE.
        state_nxt    = g_eff_read ? RWAIT : IDLE;
      end
      RWAIT: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign m0_waitrequest   = ~((state == ISSUE) && (grant == 1'b0));
  assign m1_waitrequest   = ~((state == ISSUE) && (grant == 1'b1));
  assign m0_readdatavalid = (state == RWAIT) && (grant == 1'b0);
  assign m1_readdatavalid = (state == RWAIT) && (grant == 1'b1);

  assign m0_read_data = s_read_data;
  assign m1_read_data = s_read_data;

endmodule

// File: tb/tb_gp_reg_arbiter.sv
// tb/tb_gp_reg_arbiter.sv - randomized bench for gp_reg_arbiter against a transaction-level model
module tb_gp_reg_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int DEPTH = 1 << AW;

  typedef struct {
    logic          rd;
    logic          wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            gap;
  } req_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          m0_read, m0_write, m1_read, m1_write;
  logic [AW-1:0] m0_address, m1_address;
  logic [DW-1:0] m0_write_data, m1_write_data;
  logic          m0_waitrequest, m1_waitrequest;
  logic          m0_readdatavalid, m1_readdatavalid;
  logic [DW-1:0] m0_read_data, m1_read_data;
  logic          s_read, s_write;
  logic [AW-1:0] s_address;
  logic [DW-1:0] s_write_data, s_read_data;

  gp_reg_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_read(m0_read), .m0_write(m0_write), .m0_address(m0_address),
    .m0_write_data(m0_write_data), .m0_waitrequest(m0_waitrequest),
    .m0_read_data(m0_read_data), .m0_readdatavalid(m0_readdatavalid),
    .m1_read(m1_read), .m1_write(m1_write), .m1_address(m1_address),
    .m1_write_data(m1_write_data), .m1_waitrequest(m1_waitrequest),
    .m1_read_data(m1_read_data), .m1_readdatavalid(m1_readdatavalid),
    .s_read(s_read), .s_write(s_write), .s_address(s_address),
    .s_write_data(s_write_data), .s_read_data(s_read_data)
  );

  // Register slave with one-cycle registered read latency.
  logic          clear_mem = 1'b1;
  logic [DW-1:0] smem [0:DEPTH-1];
  always @(posedge clk) begin
    if (clear_mem) begin
      for (int i = 0; i < DEPTH; i++) smem[i] <= '0;
      s_read_data <= '0;
    end else begin
      if (s_write) smem[s_address] <= s_write_data;
      if (s_read) s_read_data <= smem[s_address];
    end
  end

  // Transaction-level reference: arbiter free from free_cyc on, one pending accept and read return.
  logic [DW-1:0] mmem [0:DEPTH-1];
  int            cyc, free_cyc, acc_cyc, acc_m, rdv_cyc, rdv_m;
  logic [DW-1:0] rdv_val;
  logic          last;
  req_t          q0[$], q1[$];
  req_t          cur[2];
  logic          act[2];
  logic          acked[2];
  int            idle_cnt[2];
  int            log_m[$], log_c[$];
  logic [DW-1:0] seen_rdata;
  int            seen_rdv_m;
  int            checks = 0;
  int            failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic req_t mk(input logic rd, input logic wr, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input int gap);
    req_t r;
    r.rd = rd; r.wr = wr; r.a = a; r.d = d; r.gap = gap;
    return r;
  endfunction

  task automatic drive();
    m0_read       = act[0] & cur[0].rd;
    m0_write      = act[0] & cur[0].wr;
    m0_address    = act[0] ? cur[0].a : '0;
    m0_write_data = act[0] ? cur[0].d : '0;
    m1_read       = act[1] & cur[1].rd;
    m1_write      = act[1] & cur[1].wr;
    m1_address    = act[1] ? cur[1].a : '0;
    m1_write_data = act[1] ? cur[1].d : '0;
  endtask

  task automatic advance_master(input int m);
    req_t r;
    int   avail;
    if (act[m] && acked[m]) begin
      act[m]   = 1'b0;
      acked[m] = 1'b0;
    end
    avail = (m == 0) ? q0.size() : q1.size();
    if (!act[m] && avail > 0) begin
      if (m == 0) r = q0[0];
      else r = q1[0];
      if (idle_cnt[m] < r.gap) idle_cnt[m]++;
      else begin
        cur[m] = r;
        act[m] = 1'b1;
        idle_cnt[m] = 0;
        if (m == 0) void'(q0.pop_front());
        else void'(q1.pop_front());
      end
    end
  endtask

  task automatic step();
    logic [1:0]    ew, er, req;
    logic          esr, esw;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    int            g;
    @(posedge clk);
    #1;
    cyc++;
    advance_master(0);
    advance_master(1);
    drive();
    @(negedge clk);
    ew = 2'b11; er = 2'b00; esr = 1'b0; esw = 1'b0; ea = '0; ed = '0;
    if (acc_cyc == cyc) begin
      g = acc_m;
      ew[g] = 1'b0;
      acked[g] = 1'b1;
      esw = cur[g].wr;
      esr = cur[g].rd & ~cur[g].wr;
      ea = cur[g].a;
      ed = cur[g].d;
      if (esw) mmem[ea] = ed;
      if (esr) begin
        rdv_cyc = cyc + 1;
        rdv_m = g;
        rdv_val = mmem[ea];
      end
    end
    if (rdv_cyc == cyc) er[rdv_m] = 1'b1;
    check("m0_waitrequest", m0_waitrequest, ew[0]);
    check("m1_waitrequest", m1_waitrequest, ew[1]);
    check("m0_readdatavalid", m0_readdatavalid, er[0]);
    check("m1_readdatavalid", m1_readdatavalid, er[1]);
    check("s_read", s_read, esr);
    check("s_write", s_write, esw);
    if (esw || esr) check("s_address", s_address, ea);
    if (esw) check("s_write_data", s_write_data, ed);
    if (er[0]) check("m0_read_data", m0_read_data, rdv_val);
    if (er[1]) check("m1_read_data", m1_read_data, rdv_val);
    if (m0_readdatavalid) begin seen_rdata = m0_read_data; seen_rdv_m = 0; end
    if (m1_readdatavalid) begin seen_rdata = m1_read_data; seen_rdv_m = 1; end
    if (!m0_waitrequest) begin log_m.push_back(0); log_c.push_back(cyc); end
    if (!m1_waitrequest) begin log_m.push_back(1); log_c.push_back(cyc); end
    if (cyc >= free_cyc) begin
      req = {act[1], act[0]};
      if (req != 2'b00) begin
        if (req == 2'b11) g = last ? 0 : 1;
        else g = req[0] ? 0 : 1;
        last = g[0];
        acc_cyc = cyc + 1;
        acc_m = g;
        free_cyc = cyc + ((cur[g].rd && !cur[g].wr) ? 3 : 2);
      end
    end
  endtask

  task automatic apply_reset(input bit check_async);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    if (check_async) begin
      check("rst_m0_waitrequest", m0_waitrequest, 1'b1);
      check("rst_m1_waitrequest", m1_waitrequest, 1'b1);
      check("rst_m0_readdatavalid", m0_readdatavalid, 1'b0);
      check("rst_m1_readdatavalid", m1_readdatavalid, 1'b0);
      check("rst_s_read", s_read, 1'b0);
      check("rst_s_write", s_write, 1'b0);
    end
    q0.delete();
    q1.delete();
    for (int m = 0; m < 2; m++) begin
      act[m] = 1'b0; acked[m] = 1'b0; idle_cnt[m] = 0;
    end
    drive();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc = -1; free_cyc = 0; acc_cyc = -10; rdv_cyc = -10; last = 1'b1;
    log_m.delete();
    log_c.delete();
  endtask

  initial begin
    int n, r;
    for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
    for (int m = 0; m < 2; m++) begin
      act[m] = 1'b0; acked[m] = 1'b0; idle_cnt[m] = 0;
      cur[m] = mk(1'b0, 1'b0, '0, '0, 0);
    end
    cyc = -1;
    drive();

    apply_reset(1'b1);
    clear_mem = 1'b0;

    // Single write then a read-back from the other master.
    q0.push_back(mk(1'b0, 1'b1, 10'h004, 32'hDEADBEEF, 0));
    repeat (4) step();
    check("wr_accept_count", log_m.size(), 1);
    if (log_m.size() >= 1) begin
      check("wr_accept_master", log_m[0], 0);
      check("wr_accept_cycle", log_c[0], 1);
    end
    seen_rdata = '0;
    seen_rdv_m = -1;
    q1.push_back(mk(1'b1, 1'b0, 10'h004, 32'h0, 0));
    repeat (4) step();
    check("rd_back_data", seen_rdata, 32'hDEADBEEF);
    check("rd_back_master", seen_rdv_m, 1);

    // Continuous writes from both masters must alternate starting with m0.
    apply_reset(1'b0);
    for (int k = 0; k < 4; k++) begin
      q0.push_back(mk(1'b0, 1'b1, 10'(k), $urandom, 0));
      q1.push_back(mk(1'b0, 1'b1, 10'(k + 8), $urandom, 0));
    end
    repeat (16) step();
    check("fair_count", log_m.size(), 8);
    for (int k = 0; k < 8 && k < log_m.size(); k++) begin
      check("fair_master", log_m[k], k % 2);
      check("fair_cycle", log_c[k], 2 * k + 1);
    end

    // Read and write together resolve to a write only.
    q0.push_back(mk(1'b1, 1'b1, 10'h010, 32'h1, 0));
    repeat (4) step();

    // m1 arrives while m0's read is being issued.
    apply_reset(1'b0);
    q0.push_back(mk(1'b1, 1'b0, 10'h010, 32'h0, 0));
    q1.push_back(mk(1'b1, 1'b0, 10'h004, 32'h0, 1));
    repeat (7) step();
    check("late_count", log_m.size(), 2);
    if (log_m.size() >= 2) begin
      check("late_m0_cycle", log_c[0], 1);
      check("late_m1_master", log_m[1], 1);
      check("late_m1_cycle", log_c[1], 4);
    end

    // Reset during the read-return cycle loses the read.
    apply_reset(1'b0);
    q0.push_back(mk(1'b1, 1'b0, 10'h004, 32'h0, 0));
    n = 0;
    while (rdv_cyc != cyc + 1 && n < 8) begin
      step();
      n++;
    end
    check("rwait_reached", rdv_cyc == cyc + 1, 1'b1);
    apply_reset(1'b1);
    q0.push_back(mk(1'b0, 1'b1, 10'h020, 32'hA5A5_0001, 0));
    q1.push_back(mk(1'b0, 1'b1, 10'h021, 32'hA5A5_0002, 0));
    repeat (5) step();
    check("post_rst_count", log_m.size(), 2);
    if (log_m.size() >= 1) check("post_rst_first", log_m[0], 0);

    // Randomized traffic with small address space for read-after-write hits.
    apply_reset(1'b0);
    for (int k = 0; k < 600; k++) begin
      req_t rq;
      r = $urandom_range(0, 4);
      rq = mk(r >= 2 && r <= 4, r <= 1 || r == 4, 10'($urandom_range(0, 15)), $urandom,
              ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
      if (k % 2 == 0) q0.push_back(rq);
      else q1.push_back(rq);
    end
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || act[0] || act[1] || cyc < free_cyc + 1) && n < 6000) begin
      step();
      n++;
    end
    check("random_drain", n < 6000, 1'b1);
    for (int i = 0; i < 16; i++) check("final_mem", smem[i], mmem[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
